// File: rtl/traffic_pkg.sv
// Shared phase codes, lamp encodings, fault codes and state enum for the
// traffic-light sequence generator and its downstream phase monitor.
package traffic_pkg;
    localparam logic [1:0] PH_MG_SR = 2'b00;
    localparam logic [1:0] PH_MY_SR = 2'b01;
    localparam logic [1:0] PH_MR_SG = 2'b10;
    localparam logic [1:0] PH_MR_SY = 2'b11;

    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    typedef enum logic [1:0] {
        FC_NONE    = 2'b00,
        FC_ILLEGAL = 2'b01,
        FC_DWELL   = 2'b10
    } fault_code_e;

    typedef enum logic [1:0] {
        INIT  = 2'b00,
        RUN   = 2'b01,
        FAULT = 2'b10
    } state_e;

    // The only legal successor in the cyclic phase order.
    function automatic logic [1:0] next_phase(input logic [1:0] p);
        return p + 2'd1;
    endfunction
endpackage

// File: rtl/flash_timer.sv
// Half-period divider for the fault flash: toggle output starts ON after a
// clear and inverts every FLASH_HALF cycles while running.
module flash_timer #(
    parameter int unsigned FLASH_HALF = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    output logic toggle_o
);
    logic [31:0] cnt_q;
    logic        tog_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            tog_q <= 1'b1;
        end else if (clr_i) begin
            cnt_q <= '0;
            tog_q <= 1'b1;
        end else if (cnt_q == FLASH_HALF - 32'd1) begin
            cnt_q <= '0;
            tog_q <= ~tog_q;
        end else begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign toggle_o = tog_q;
endmodule

// File: rtl/traffic_phase_monitor.sv
// Checks the generator's phase stream for cyclic order and minimum dwell,
// drives the lamps, and latches a flashing-yellow fault on any violation.
module traffic_phase_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned MIN_DWELL  = 20,
    parameter int unsigned FLASH_HALF = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  phase_in,
    input  logic        fault_clr,
    output logic [2:0]  main_lamp,
    output logic [2:0]  side_lamp,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [31:0] phase_cycles
);
    state_e      state_q, state_d;
    fault_code_e code_q, code_d;
    logic [1:0]  phase_q, prev_q, prev_d;
    logic [31:0] cycles_q, cycles_d;
    logic        armed_q, armed_d;
    logic        flash_on;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= INIT;
            code_q   <= FC_NONE;
            phase_q  <= PH_MG_SR;
            prev_q   <= PH_MG_SR;
            cycles_q <= '0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            phase_q  <= phase_in;
            prev_q   <= prev_d;
            cycles_q <= cycles_d;
            armed_q  <= armed_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        prev_d   = prev_q;
        cycles_d = cycles_q;
        armed_d  = armed_q;
        case (state_q)
            INIT: begin
                // First phase after INIT is taken on trust; its dwell is unknown.
                prev_d   = phase_q;
                cycles_d = 32'd1;
                armed_d  = 1'b0;
                code_d   = FC_NONE;
                state_d  = RUN;
            end
            RUN: begin
                if (phase_q == prev_q) begin
                    if (cycles_q != '1) cycles_d = cycles_q + 32'd1;
                end else if (phase_q != next_phase(prev_q)) begin
                    state_d = FAULT;
                    code_d  = FC_ILLEGAL;
                end else if (armed_q && (cycles_q < MIN_DWELL)) begin
                    state_d = FAULT;
                    code_d  = FC_DWELL;
                end else begin
                    prev_d   = phase_q;
                    cycles_d = 32'd1;
                    armed_d  = 1'b1;
                end
            end
            FAULT: begin
                if (fault_clr) begin
                    state_d  = INIT;
                    code_d   = FC_NONE;
                    cycles_d = '0;
                end
            end
            default: state_d = INIT;
        endcase
    end

    flash_timer #(.FLASH_HALF(FLASH_HALF)) u_flash (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (state_q != FAULT),
        .toggle_o (flash_on)
    );

    always_comb begin
        main_lamp = LAMP_R;
        side_lamp = LAMP_R;
        case (state_q)
            RUN: begin
                case (prev_q)
                    PH_MG_SR: begin main_lamp = LAMP_G; side_lamp = LAMP_R; end
                    PH_MY_SR: begin main_lamp = LAMP_Y; side_lamp = LAMP_R; end
                    PH_MR_SG: begin main_lamp = LAMP_R; side_lamp = LAMP_G; end
                    default:  begin main_lamp = LAMP_R; side_lamp = LAMP_Y; end
                endcase
            end
            FAULT: begin
                main_lamp = flash_on ? LAMP_Y : LAMP_OFF;
                side_lamp = flash_on ? LAMP_Y : LAMP_OFF;
            end
            default: ;
        endcase
    end

    assign fault        = (state_q == FAULT);
    assign fault_code   = code_q;
    assign phase_cycles = cycles_q;
endmodule

// File: tb/tb_traffic_phase_monitor.sv
// Directed bench for traffic_phase_monitor: reset, legal cycle, illegal jump
// with flash timing, dwell boundary, priority/clear, async reset, saturation.
module tb_traffic_phase_monitor;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  phase_in = 2'b00;
    logic        fault_clr = 1'b0;
    logic [2:0]  main_lamp, side_lamp;
    logic        fault;
    logic [1:0]  fault_code;
    logic [31:0] phase_cycles;

    int total = 0;
    int bad = 0;

    traffic_phase_monitor #(.MIN_DWELL(20), .FLASH_HALF(50)) dut (
        .clk          (clk),
        .reset        (reset),
        .phase_in     (phase_in),
        .fault_clr    (fault_clr),
        .main_lamp    (main_lamp),
        .side_lamp    (side_lamp),
        .fault        (fault),
        .fault_code   (fault_code),
        .phase_cycles (phase_cycles)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] run_lamps(input logic [1:0] p);
        case (p)
            2'b00:   return 6'b001_100;
            2'b01:   return 6'b010_100;
            2'b10:   return 6'b100_001;
            default: return 6'b100_010;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1; phase_in = 2'b00; fault_clr = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        total++; if ({main_lamp, side_lamp} !== 6'b100_100) begin bad++; $display("FAIL rst_lamps got=%b want=%b", {main_lamp, side_lamp}, 6'b100_100); end
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL rst_fault got=%b want=0", fault); end
        total++; if (fault_code !== 2'b00) begin bad++; $display("FAIL rst_code got=%b want=00", fault_code); end
        total++; if (phase_cycles !== 32'd0) begin bad++; $display("FAIL rst_cycles got=%0d want=0", phase_cycles); end
        reset = 1'b0;
        step(2);
        total++; if ({main_lamp, side_lamp} !== 6'b001_100) begin bad++; $display("FAIL rst_release_lamps got=%b want=%b", {main_lamp, side_lamp}, 6'b001_100); end
    endtask

    task automatic test_legal_cycle();
        logic [1:0] seq [4];
        seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b00;
        step(23);
        for (int i = 0; i < 4; i++) begin
            phase_in = seq[i];
            step(1);
            if (i > 0) begin
                total++; if (phase_cycles !== 32'd25) begin bad++; $display("FAIL legal_peak%0d got=%0d want=25", i, phase_cycles); end
            end
            step(1);
            total++; if ({main_lamp, side_lamp} !== run_lamps(seq[i])) begin bad++; $display("FAIL legal_lamps%0d got=%b want=%b", i, {main_lamp, side_lamp}, run_lamps(seq[i])); end
            total++; if (fault !== 1'b0 || phase_cycles !== 32'd1) begin bad++; $display("FAIL legal_state%0d got fault=%b cyc=%0d want fault=0 cyc=1", i, fault, phase_cycles); end
            step(23);
        end
    endtask

    task automatic test_illegal_jump();
        step(6);
        phase_in = 2'b10;
        step(1);
        total++; if (fault !== 1'b0 || phase_cycles !== 32'd31) begin bad++; $display("FAIL jump_pre got fault=%b cyc=%0d want fault=0 cyc=31", fault, phase_cycles); end
        step(1);
        total++; if (fault !== 1'b1 || fault_code !== 2'b01) begin bad++; $display("FAIL jump_fault got fault=%b code=%b want fault=1 code=01", fault, fault_code); end
        total++; if ({main_lamp, side_lamp} !== 6'b010_010) begin bad++; $display("FAIL jump_flash_on got=%b want=%b", {main_lamp, side_lamp}, 6'b010_010); end
        phase_in = 2'b01;
        step(49);
        total++; if ({main_lamp, side_lamp} !== 6'b010_010) begin bad++; $display("FAIL flash_on_end got=%b want=%b", {main_lamp, side_lamp}, 6'b010_010); end
        step(1);
        total++; if ({main_lamp, side_lamp} !== 6'b000_000) begin bad++; $display("FAIL flash_off got=%b want=%b", {main_lamp, side_lamp}, 6'b000_000); end
        step(49);
        total++; if ({main_lamp, side_lamp} !== 6'b000_000 || phase_cycles !== 32'd31) begin bad++; $display("FAIL flash_off_end got lamps=%b cyc=%0d want lamps=000000 cyc=31", {main_lamp, side_lamp}, phase_cycles); end
        step(1);
        total++; if ({main_lamp, side_lamp} !== 6'b010_010 || fault_code !== 2'b01) begin bad++; $display("FAIL flash_reon got lamps=%b code=%b want lamps=010010 code=01", {main_lamp, side_lamp}, fault_code); end
        phase_in = 2'b00; fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        total++; if ({main_lamp, side_lamp} !== 6'b100_100 || fault !== 1'b0 || fault_code !== 2'b00 || phase_cycles !== 32'd0) begin bad++; $display("FAIL clr_init got lamps=%b f=%b code=%b cyc=%0d want 100100 0 00 0", {main_lamp, side_lamp}, fault, fault_code, phase_cycles); end
        step(1);
        total++; if ({main_lamp, side_lamp} !== 6'b001_100 || fault !== 1'b0) begin bad++; $display("FAIL clr_run got lamps=%b f=%b want 001100 0", {main_lamp, side_lamp}, fault); end
    endtask

    task automatic test_dwell_boundary();
        phase_in = 2'b01;
        step(20);
        phase_in = 2'b10;
        step(1);
        total++; if (phase_cycles !== 32'd20) begin bad++; $display("FAIL dwell20_count got=%0d want=20", phase_cycles); end
        step(1);
        total++; if (fault !== 1'b0 || {main_lamp, side_lamp} !== 6'b100_001) begin bad++; $display("FAIL dwell20_ok got f=%b lamps=%b want 0 100001", fault, {main_lamp, side_lamp}); end
        step(17);
        phase_in = 2'b11;
        step(1);
        total++; if (phase_cycles !== 32'd19 || fault !== 1'b0) begin bad++; $display("FAIL dwell19_count got cyc=%0d f=%b want 19 0", phase_cycles, fault); end
        step(1);
        total++; if (fault !== 1'b1 || fault_code !== 2'b10 || {main_lamp, side_lamp} !== 6'b010_010) begin bad++; $display("FAIL dwell19_fault got f=%b code=%b lamps=%b want 1 10 010010", fault, fault_code, {main_lamp, side_lamp}); end
    endtask

    task automatic test_priority_clear();
        phase_in = 2'b00; fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        step(1);
        phase_in = 2'b01;
        step(25);
        phase_in = 2'b10;
        step(5);
        total++; if ({main_lamp, side_lamp} !== 6'b100_001) begin bad++; $display("FAIL prio_pre_lamps got=%b want=%b", {main_lamp, side_lamp}, 6'b100_001); end
        phase_in = 2'b00;
        step(2);
        total++; if (fault !== 1'b1 || fault_code !== 2'b01 || phase_cycles !== 32'd5) begin bad++; $display("FAIL prio_code got f=%b code=%b cyc=%0d want 1 01 5", fault, fault_code, phase_cycles); end
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        total++; if ({main_lamp, side_lamp} !== 6'b100_100 || fault !== 1'b0) begin bad++; $display("FAIL prio_clr_init got lamps=%b f=%b want 100100 0", {main_lamp, side_lamp}, fault); end
        step(1);
        total++; if ({main_lamp, side_lamp} !== 6'b001_100 || fault !== 1'b0 || phase_cycles !== 32'd1) begin bad++; $display("FAIL prio_unchecked got lamps=%b f=%b cyc=%0d want 001100 0 1", {main_lamp, side_lamp}, fault, phase_cycles); end
        step(3);
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        total++; if (fault !== 1'b0 || {main_lamp, side_lamp} !== 6'b001_100 || phase_cycles !== 32'd5) begin bad++; $display("FAIL clr_in_run got f=%b lamps=%b cyc=%0d want 0 001100 5", fault, {main_lamp, side_lamp}, phase_cycles); end
    endtask

    task automatic test_async_reset_saturation();
        phase_in = 2'b10;
        step(2);
        total++; if (fault !== 1'b1 || fault_code !== 2'b01) begin bad++; $display("FAIL ar_fault got f=%b code=%b want 1 01", fault, fault_code); end
        step(10);
        #2;
        reset = 1'b1;
        #1;
        total++; if ({main_lamp, side_lamp} !== 6'b100_100 || fault !== 1'b0 || fault_code !== 2'b00 || phase_cycles !== 32'd0) begin bad++; $display("FAIL async_reset got lamps=%b f=%b code=%b cyc=%0d want 100100 0 00 0", {main_lamp, side_lamp}, fault, fault_code, phase_cycles); end
        step(3);
        phase_in = 2'b00;
        reset = 1'b0;
        step(2);
        total++; if ({main_lamp, side_lamp} !== 6'b001_100 || phase_cycles !== 32'd2) begin bad++; $display("FAIL ar_restart got lamps=%b cyc=%0d want 001100 2", {main_lamp, side_lamp}, phase_cycles); end
        force dut.cycles_q = 32'hFFFF_FFFE;
        #1;
        release dut.cycles_q;
        step(1);
        total++; if (phase_cycles !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_reach got=%h want=ffffffff", phase_cycles); end
        step(3);
        total++; if (phase_cycles !== 32'hFFFF_FFFF || fault !== 1'b0) begin bad++; $display("FAIL sat_hold got cyc=%h f=%b want ffffffff 0", phase_cycles, fault); end
    endtask

    initial begin
        test_reset();
        test_legal_cycle();
        test_illegal_jump();
        test_dwell_boundary();
        test_priority_clear();
        test_async_reset_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
